// File: rtl/mux_route_if.sv
// mux_route_if: request/route bundle between requesters and the route scheduler
interface mux_route_if;
  logic [3:0] src_req;
  logic [7:0] src_dst;
  logic [1:0] mux_sel;
  logic [1:0] demux_sel;
  logic       path_en;
  logic [3:0] gnt;
  logic [3:0] done;
  logic       busy;
  modport master (output src_req, src_dst, input mux_sel, demux_sel, path_en, gnt, done, busy);
  modport slave  (input src_req, src_dst, output mux_sel, demux_sel, path_en, gnt, done, busy);
endinterface

// File: rtl/mux_route_scheduler.sv
// mux_route_scheduler: round-robin owner of the shared mux->demux path with hold and break-before-make gap
module mux_route_scheduler #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input logic        clk,
  input logic        rst_n,
  mux_route_if.slave bus
);
  localparam int MX = HOLD_CYCLES > GAP_CYCLES ? (HOLD_CYCLES > 2 ? HOLD_CYCLES : 2) : (GAP_CYCLES > 2 ? GAP_CYCLES : 2);
  localparam int CW = $clog2(MX);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  localparam state_t AFTER = GAP_CYCLES > 0 ? GAP : IDLE;
  state_t state_q, state_d;
  logic [1:0] mux_sel_q, mux_sel_d, demux_sel_q, demux_sel_d, last_q, last_d, win, cand;
  logic [3:0] gnt_q, gnt_d, done_q, done_d;
  logic path_en_q, path_en_d, busy_q, busy_d, found;
  logic [CW-1:0] cnt_q, cnt_d;
  // state register; reset leaves src0 with top priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mux_sel_q   <= '0;
      demux_sel_q <= '0;
      last_q      <= 2'd3;
      gnt_q       <= '0;
      done_q      <= '0;
      path_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mux_sel_q   <= mux_sel_d;
      demux_sel_q <= demux_sel_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      path_en_q   <= path_en_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end
  // round-robin pick: first requester after the last granted one
  always_comb begin
    win   = last_q;
    found = 1'b0;
    cand  = last_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!found && bus.src_req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end
  // next state: a dropped request ends the hold early just like expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = |bus.src_req ? HOLD : IDLE;
      HOLD:    state_d = (!bus.src_req[mux_sel_q] || cnt_q == '0) ? AFTER : HOLD;
      GAP:     state_d = cnt_q == '0 ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
  end
  // registered outputs; selects stay put outside a grant so the path never glitches
  always_comb begin
    mux_sel_d   = mux_sel_q;
    demux_sel_d = demux_sel_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    path_en_d   = path_en_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: if (|bus.src_req) begin
        mux_sel_d   = win;
        demux_sel_d = bus.src_dst[{win, 1'b0} +: 2];
        gnt_d       = 4'b1 << win;
        path_en_d   = 1'b1;
        busy_d      = 1'b1;
        last_d      = win;
        cnt_d       = HOLD_LD;
      end
      HOLD: if (!bus.src_req[mux_sel_q] || cnt_q == '0) begin
        done_d    = bus.src_req[mux_sel_q] ? gnt_q : 4'b0;
        gnt_d     = '0;
        path_en_d = 1'b0;
        busy_d    = GAP_CYCLES > 0;
        cnt_d     = GAP_LD;
      end else cnt_d = cnt_q - 1'b1;
      GAP: if (cnt_q == '0) busy_d = 1'b0;
        else cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end
  assign bus.mux_sel   = mux_sel_q;
  assign bus.demux_sel = demux_sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.path_en   = path_en_q;
  assign bus.busy      = busy_q;
endmodule
